// File: rtl/counter_ud_ctrl.sv
// counter_ud_ctrl: run sequencer for the 4-bit up/down LED counter.
// It turns the start/stop buttons into run/pause/abort events. A prescaler
// paces the counter steps. The controller chooses the step direction from the
// selected mode and from the counter value it reads back. It also issues the
// one-cycle clear that starts every fresh run.
module counter_ud_ctrl #(
    parameter int WIDTH = 4,   // width of the counter value
    parameter int DIV   = 4,   // clk cycles per counter step, must be >= 2
    parameter int MAXV  = 15,  // upper limit: ping-pong reversal, sweep end
    parameter int MINV  = 0    // lower limit: ping-pong reversal
) (
    input  logic             clk,
    input  logic             reset,    // synchronous, active-high
    input  logic             start,    // level button, rising edge = start/resume
    input  logic             stop,     // level button, rising edge = pause/abort
    input  logic [1:0]       mode,     // 00 up, 01 down, 10 ping-pong, 11 sweep
    input  logic [WIDTH-1:0] count,    // registered value fed back from the counter
    output logic             UD,       // 1 = count up, 0 = count down
    output logic             cnt_en,   // one-cycle step enable
    output logic             cnt_clr,  // one-cycle synchronous clear
    output logic             busy,     // high in RUN or HOLD
    output logic             done,     // one-cycle pulse when a sweep completes
    output logic [1:0]       state     // IDLE=00 RUN=01 HOLD=10 DONE=11
);

    // Prescaler width. DIV >= 2, so at least one bit is always needed.
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] LIM_MAX    = WIDTH'(MAXV);
    localparam logic [WIDTH-1:0] LIM_MIN    = WIDTH'(MINV);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PP   = 2'b10;
    localparam logic [1:0] MODE_SWP  = 2'b11;

    // The encoding is visible on the state port, so keep it fixed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Registered state
    state_t          state_q,   state_d;
    logic [PW-1:0]   presc_q,   presc_d;
    logic [1:0]      mode_q,    mode_d;
    logic            ud_q,      ud_d;
    logic            cnt_en_q,  cnt_en_d;
    logic            cnt_clr_q, cnt_clr_d;
    logic            done_q,    done_d;
    logic            start_q,   start_d;
    logic            stop_q,    stop_d;

    // Decoded events and per-step decisions
    logic            start_ev;
    logic            stop_ev;
    logic            tick;
    logic            dir_n;
    logic            at_max;
    logic            at_min;
    logic            sweep_end;

    // Button edge detection. A held button yields exactly one event. When both
    // buttons rise in the same cycle, stop takes priority and start is dropped.
    always_comb begin
        start_d  = start;
        stop_d   = stop;
        stop_ev  = stop & ~stop_q;
        start_ev = start & ~start_q & ~stop_ev;
    end

    // Direction for the next step and detection of the sweep end point.
    // This uses the counter value as it stands before the step.
    always_comb begin
        at_max    = (count == LIM_MAX);
        at_min    = (count == LIM_MIN);
        tick      = (presc_q == PRESC_LAST);
        sweep_end = (mode_q == MODE_SWP) && at_max;
        dir_n     = ud_q;
        case (mode_q)
            MODE_UP:   dir_n = 1'b1;
            MODE_DOWN: dir_n = 1'b0;
            MODE_PP: begin
                if (at_max && ud_q) begin
                    dir_n = 1'b0;
                end else if (at_min && !ud_q) begin
                    dir_n = 1'b1;
                end else begin
                    dir_n = ud_q;
                end
            end
            default:   dir_n = 1'b1;  // a sweep always counts up
        endcase
    end

    // Next-state logic and the registered output pulses.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        mode_d    = mode_q;
        ud_d      = ud_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    // A fresh run latches the mode and clears the counter.
                    // It also restarts the prescaler from zero.
                    state_d   = ST_RUN;
                    mode_d    = mode;
                    cnt_clr_d = 1'b1;
                    presc_d   = '0;
                    ud_d      = (mode != MODE_DOWN);
                end
            end

            ST_RUN: begin
                if (stop_ev) begin
                    // A pause freezes the prescaler where it is, so a resume
                    // keeps the step rhythm.
                    state_d = ST_HOLD;
                end else if (tick) begin
                    presc_d = '0;
                    if (sweep_end) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        ud_d     = dir_n;
                        cnt_en_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            ST_HOLD: begin
                if (stop_ev) begin
                    state_d = ST_IDLE;
                end else if (start_ev) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. Reset does not raise cnt_clr; only a start does.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            mode_q    <= MODE_UP;
            ud_q      <= 1'b1;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            mode_q    <= mode_d;
            ud_q      <= ud_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
        end
    end

    // Output mapping
    always_comb begin
        UD      = ud_q;
        cnt_en  = cnt_en_q;
        cnt_clr = cnt_clr_q;
        done    = done_q;
        state   = state_q;
        busy    = (state_q == ST_RUN) || (state_q == ST_HOLD);
    end

endmodule

// File: tb/tb_counter_ud_ctrl.sv
// Bench for counter_ud_ctrl. A simple up/down counter closes the count loop.
// An abstract run model predicts every output on every cycle. Directed scenarios
// then pin the model with hand-computed count trajectories and pulse counts.
module tb_counter_ud_ctrl;

    localparam int WIDTH = 4;
    localparam int DIV   = 4;
    localparam int MAXV  = 15;
    localparam int MINV  = 0;
    localparam int MODN  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             UD;
    logic             cnt_en;
    logic             cnt_clr;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    counter_ud_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .MAXV(MAXV), .MINV(MINV)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .count(count), .UD(UD), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .busy(busy), .done(done), .state(state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // The counter that the controller drives. It feeds count back to the DUT.
    always @(posedge clk) begin
        if (reset)        count <= '0;
        else if (cnt_clr) count <= '0;
        else if (cnt_en)  count <= UD ? count + WIDTH'(1) : count - WIDTH'(1);
    end

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Abstract run model. Phases: 0 idle, 1 running, 2 paused, 3 finished.
    int m_st, m_pre, m_mode, m_count, m_c;
    bit m_ud, m_en, m_clr, m_done, m_sp, m_tp, m_sev, m_tev;

    always @(posedge clk) begin
        if (reset) begin
            m_st = 0; m_pre = 0; m_mode = 0; m_count = 0;
            m_ud = 1; m_en = 0; m_clr = 0; m_done = 0; m_sp = 0; m_tp = 0;
        end else begin
            m_c = m_count;  // the value the controller sees this edge
            if (m_clr)     m_count = 0;
            else if (m_en) m_count = m_ud ? (m_count + 1) % MODN : (m_count + MODN - 1) % MODN;
            m_tev = stop && !m_tp;
            m_sev = start && !m_sp && !m_tev;
            m_sp = start; m_tp = stop;
            m_en = 0; m_clr = 0; m_done = 0;
            if (m_st == 0) begin
                if (m_sev) begin
                    m_st = 1; m_mode = int'(mode); m_clr = 1; m_pre = 0; m_ud = (mode != 2'b01);
                end
            end else if (m_st == 1) begin
                if (m_tev) m_st = 2;
                else if (++m_pre == DIV) begin
                    m_pre = 0;
                    if (m_mode == 3 && m_c == MAXV) begin
                        m_st = 3; m_done = 1;
                    end else begin
                        // Ping-pong: head down at the top, up at the bottom.
                        if (m_mode == 0 || m_mode == 3) m_ud = 1;
                        else if (m_mode == 1)           m_ud = 0;
                        else if (m_c == MAXV)           m_ud = 0;
                        else if (m_c == MINV)           m_ud = 1;
                        m_en = 1;
                    end
                end
            end else if (m_st == 2) begin
                if (m_tev)      m_st = 0;
                else if (m_sev) m_st = 1;
            end else begin
                m_st = 0;
            end
        end
    end

    // Compare process: every cycle, all outputs against the model.
    logic [6:0] exp_v, act_v;
    always @(negedge clk) begin
        if (chk_on) begin
            exp_v = {m_st[1:0], m_ud, m_en, m_clr, (m_st == 1 || m_st == 2), m_done};
            act_v = {state, UD, cnt_en, cnt_clr, busy, done};
            chk("outputs_vs_model", int'(act_v), int'(exp_v));
            chk("count_vs_model", int'(count), m_count);
        end
    end

    // Scenario logs, used by the directed checks.
    int cyc = 0, en_n, clr_n, done_n, last_count, last_state;
    int en_cyc[$];
    int ud_at_en[$];
    int traj[$];
    int st_log[$];
    int exp_q[$];

    always @(negedge clk) begin
        if (chk_on) begin
            cyc++;
            if (cnt_en) begin
                en_n++; en_cyc.push_back(cyc); ud_at_en.push_back(int'(UD));
            end
            if (cnt_clr) clr_n++;
            if (done) done_n++;
            if (int'(count) != last_count) begin
                traj.push_back(int'(count)); last_count = int'(count);
            end
            if (int'(state) != last_state) begin
                st_log.push_back(int'(state)); last_state = int'(state);
            end
        end
    end

    // Driver tasks. Inputs change 1 time unit after the falling edge.
    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        en_n = 0; clr_n = 0; done_n = 0;
        en_cyc.delete(); ud_at_en.delete(); traj.delete(); st_log.delete();
        last_count = int'(count); last_state = int'(state);
    endtask

    task automatic wait_en(int target, int budget, string name);
        int k = 0;
        while (en_n < target && k < budget) begin
            tick();
            k++;
        end
        chk(name, en_n, target);
    endtask

    task automatic press_start(logic [1:0] m);
        mode = m; start = 1'b1; tick(); start = 1'b0;
    endtask

    // Two stop presses: RUN -> HOLD -> IDLE.
    task automatic go_idle();
        start = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0; tick();
        stop = 1'b1; tick(); stop = 1'b0; tick();
    endtask

    function automatic int queue_diff(string name);
        int bad = 0;
        chk({name, "_len"}, traj.size(), exp_q.size());
        foreach (exp_q[i]) if (i >= traj.size() || traj[i] != exp_q[i]) bad++;
        return bad;
    endfunction

    initial begin
        int bad, k;
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;

        // 1: reset held for 3 cycles
        tick();
        chk_on = 1'b1;
        tick(2);
        chk("reset_vec", int'({state, UD, cnt_en, cnt_clr, busy, done}), int'(7'b0010000));
        reset = 1'b0;
        tick();
        clear_logs();

        // 2: up mode with start held high; 16 steps: 1..15 then wrap to 0
        mode = 2'b00; start = 1'b1;
        wait_en(16, 100, "up_steps");
        go_idle();
        chk("up_one_clr", clr_n, 1);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back((i + 1) % 16);
        chk("up_traj", queue_diff("up_traj"), 0);
        bad = 0;
        for (int i = 1; i < en_cyc.size(); i++) if (en_cyc[i] - en_cyc[i-1] != 4) bad++;
        chk("up_en_spacing", bad, 0);
        bad = 0;
        foreach (ud_at_en[i]) if (ud_at_en[i] != 1) bad++;
        chk("up_ud_high", bad, 0);
        chk("up_idle", int'(state), 0);

        // 3: ping-pong 1..15,14..0,1; a mode change mid-run is ignored
        clear_logs();
        press_start(2'b10);
        wait_en(8, 60, "pp_first8");
        mode = 2'b01;
        wait_en(31, 150, "pp_steps");
        go_idle();
        exp_q.delete();
        for (int i = 1; i <= 15; i++) exp_q.push_back(i);
        for (int i = 14; i >= 0; i--) exp_q.push_back(i);
        exp_q.push_back(1);
        chk("pp_traj", queue_diff("pp_traj"), 0);
        bad = 0;
        foreach (ud_at_en[i]) if (ud_at_en[i] != ((i < 15 || i == 30) ? 1 : 0)) bad++;
        chk("pp_ud_at_en", bad, 0);
        chk("pp_ud_fall", ud_at_en.size() > 15 ? ud_at_en[15] : -1, 0);
        chk("pp_ud_rise", ud_at_en.size() > 30 ? ud_at_en[30] : -1, 1);

        // 4: sweep up to 15, then done pulse and state 01 -> 11 -> 00
        clear_logs();
        press_start(2'b11);
        k = 0;
        while (done_n == 0 && k < 200) begin tick(); k++; end
        chk("sweep_done_seen", done_n, 1);
        tick(3);
        chk("sweep_steps", en_n, 15);
        chk("sweep_done_once", done_n, 1);
        chk("sweep_final_count", int'(count), 15);
        chk("sweep_states_len", st_log.size(), 3);
        chk("sweep_state0", st_log.size() > 0 ? st_log[0] : -1, 1);
        chk("sweep_state1", st_log.size() > 1 ? st_log[1] : -1, 3);
        chk("sweep_state2", st_log.size() > 2 ? st_log[2] : -1, 0);

        // 5: pause at count 5, hold 40 cycles, resume without clear -> 6
        clear_logs();
        press_start(2'b00);
        k = 0;
        while (!(int'(count) == 5 && state == 2'b01) && k < 100) begin tick(); k++; end
        chk("hold_reach5", int'(count), 5);
        stop = 1'b1; tick(); stop = 1'b0;
        tick(40);
        chk("hold_state", int'(state), 2);
        chk("hold_count", int'(count), 5);
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;
        chk("resume_state", int'(state), 1);
        wait_en(1, 20, "resume_step");
        tick();
        chk("resume_count", int'(count), 6);
        chk("resume_no_clr", clr_n, 0);
        go_idle();

        // 6: simultaneous start/stop in IDLE; reset during a run
        clear_logs();
        start = 1'b1; stop = 1'b1; tick(); tick(3);
        chk("both_idle", int'(state), 0);
        chk("both_no_clr", clr_n, 0);
        start = 1'b0; stop = 1'b0; tick();
        clear_logs();
        press_start(2'b00);
        wait_en(2, 30, "rst_run_steps");
        reset = 1'b1; tick();
        chk("rst_mid_vec", int'({state, UD, cnt_en, busy}), int'(5'b00100));
        reset = 1'b0; tick(2);
        chk("rst_after_state", int'(state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
